// File: rtl/dpram_rr_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter: request fields flow from
// the client engines, grants and read returns flow back.
interface dpram_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [NUM_REQ*DATA_WIDTH-1:0] rdata;

    // Client engines drive requests and consume grants and read returns.
    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rvalid, rdata
    );

    // The arbiter observes requests and drives grants and read returns.
    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among NUM_REQ requesters.
// Up to two grants per cycle (A -> RAM port A, B -> RAM port B); RAM controls
// are registered, and a per-port tag pipeline routes read data back to the
// requester that issued the read after a fixed latency.
module dpram_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int RAM_RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dpram_rr_arbiter_if.slave     cli,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_en_a,
    output logic                  ram_we_a,
    input  logic [DATA_WIDTH-1:0] ram_q_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_en_b,
    output logic                  ram_we_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int DEPTH = RAM_RD_LAT + 1;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } rd_tag_t;

    // (base + k) mod NUM_REQ, valid for base < NUM_REQ and k < NUM_REQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDW'(sum);
    endfunction

    logic [IDW-1:0]            ptr_q, ptr_d;
    logic [IDW-1:0]            a_idx, b_idx;
    logic                      a_found, b_found, b_ok;
    logic                      a_we, b_we;
    logic [ADDR_WIDTH-1:0]     a_addr, b_addr;
    logic [DATA_WIDTH-1:0]     a_wdata, b_wdata;
    logic [NUM_REQ-1:0]        gnt_d;
    logic                      busy_a, busy_b;
    logic [NUM_REQ-1:0]        rvalid_q, rvalid_d;
    logic [NUM_REQ*DATA_WIDTH-1:0] rdata_q, rdata_d;
    rd_tag_t                   pipe_a_q [DEPTH];
    rd_tag_t                   pipe_b_q [DEPTH];

    // Round-robin scan: first two requesters found starting at the pointer.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cli.req[wrap_add(ptr_q, k)]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = wrap_add(ptr_q, k);
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = wrap_add(ptr_q, k);
                end
            end
        end
    end

    assign a_we    = cli.req_we[a_idx];
    assign b_we    = cli.req_we[b_idx];
    assign a_addr  = cli.req_addr[a_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign b_addr  = cli.req_addr[b_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign a_wdata = cli.req_wdata[a_idx*DATA_WIDTH +: DATA_WIDTH];
    assign b_wdata = cli.req_wdata[b_idx*DATA_WIDTH +: DATA_WIDTH];

    // Grant decision: B is deferred on a same-address write pair; the pointer
    // moves just past the last requester granted.
    always_comb begin
        b_ok  = b_found && !(a_we && b_we && (a_addr == b_addr));
        gnt_d = '0;
        ptr_d = ptr_q;
        if (a_found) begin
            gnt_d[a_idx] = 1'b1;
            ptr_d        = wrap_add(a_idx, 1);
        end
        if (b_ok) begin
            gnt_d[b_idx] = 1'b1;
            ptr_d        = wrap_add(b_idx, 1);
        end
    end

    assign cli.gnt = rst ? '0 : gnt_d;

    // A port keeps its enable high while a read is still inside the RAM so the
    // RAM's output register is not cleared before the tap samples it.
    always_comb begin
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int d = 0; d < RAM_RD_LAT; d++) begin
            busy_a = busy_a | pipe_a_q[d].valid;
            busy_b = busy_b | pipe_b_q[d].valid;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    // Registered RAM controls; address/data hold when a port is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en_a   <= 1'b0;
            ram_we_a   <= 1'b0;
            ram_addr_a <= '0;
            ram_data_a <= '0;
            ram_en_b   <= 1'b0;
            ram_we_b   <= 1'b0;
            ram_addr_b <= '0;
            ram_data_b <= '0;
        end else begin
            ram_en_a <= a_found | busy_a;
            ram_we_a <= a_found & a_we;
            if (a_found) begin
                ram_addr_a <= a_addr;
                ram_data_a <= a_wdata;
            end
            ram_en_b <= b_ok | busy_b;
            ram_we_b <= b_ok & b_we;
            if (b_ok) begin
                ram_addr_b <= b_addr;
                ram_data_b <= b_wdata;
            end
        end
    end

    // Per-port read tag pipelines aligned with the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the tag pipeline is reset (unlike a data array) so reads in flight at reset never return.
            for (int d = 0; d < DEPTH; d++) begin
                pipe_a_q[d] <= '0;
                pipe_b_q[d] <= '0;
            end
        end else begin
            pipe_a_q[0].valid <= a_found & ~a_we;
            pipe_a_q[0].id    <= a_idx;
            pipe_b_q[0].valid <= b_ok & ~b_we;
            pipe_b_q[0].id    <= b_idx;
            for (int d = 1; d < DEPTH; d++) begin
                pipe_a_q[d] <= pipe_a_q[d-1];
                pipe_b_q[d] <= pipe_b_q[d-1];
            end
        end
    end

    // Return steering: the tap of each pipeline picks the destination requester.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (pipe_a_q[DEPTH-1].valid) begin
            rvalid_d[pipe_a_q[DEPTH-1].id] = 1'b1;
            rdata_d[pipe_a_q[DEPTH-1].id*DATA_WIDTH +: DATA_WIDTH] = ram_q_a;
        end
        if (pipe_b_q[DEPTH-1].valid) begin
            rvalid_d[pipe_b_q[DEPTH-1].id] = 1'b1;
            rdata_d[pipe_b_q[DEPTH-1].id*DATA_WIDTH +: DATA_WIDTH] = ram_q_b;
        end
    end

    // Registered read-return strobe and per-requester data hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cli.rvalid = rvalid_q;
    assign cli.rdata  = rdata_q;
endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Directed bench for dpram_rr_arbiter with a behavioural dual-port RAM
// (two output register stages, output cleared when the port is disabled).
module tb_dpram_rr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dpram_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b, stg_a, stg_b;
    logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
    logic [DW-1:0] mem [32];
    logic [29:0]   ram_ctl;

    assign ram_ctl = {ram_en_a, ram_we_a, ram_addr_a, ram_data_a,
                      ram_en_b, ram_we_b, ram_addr_b, ram_data_b};

    dpram_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_RD_LAT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cli        (bus),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_en_a   (ram_en_a),
        .ram_we_a   (ram_we_a),
        .ram_q_a    (ram_q_a),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_en_b   (ram_en_b),
        .ram_we_b   (ram_we_b),
        .ram_q_b    (ram_q_b)
    );

    // RAM model: image loaded while rst is high (0x80+addr above 15, else 0),
    // read data valid two edges after sampling, read-before-write per port.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i >= 16) ? 8'(8'h80 + i) : 8'h00;
            stg_a <= '0; ram_q_a <= '0;
            stg_b <= '0; ram_q_b <= '0;
        end else begin
            if (ram_en_a) begin stg_a <= mem[ram_addr_a]; ram_q_a <= stg_a; end
            else          begin stg_a <= '0;              ram_q_a <= '0;    end
            if (ram_en_b) begin stg_b <= mem[ram_addr_b]; ram_q_b <= stg_b; end
            else          begin stg_b <= '0;              ram_q_b <= '0;    end
            if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_data_a;
            if (ram_en_b && ram_we_b) mem[ram_addr_b] <= ram_data_b;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.req[i]              = 1'b1;
        bus.req_we[i]           = we;
        bus.req_addr[i*AW +: AW] = addr;
        bus.req_wdata[i*DW +: DW] = wd;
    endtask

    function automatic logic [DW-1:0] rd(input int i);
        return bus.rdata[i*DW +: DW];
    endfunction

    // Power-on reset with requests asserted: every output must be 0.
    task automatic test_reset();
        rst = 1'b1;
        clear_req();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 5'(16 + i), 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        n_checks++;
        if (bus.rvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0000", bus.rvalid); end
        n_checks++;
        if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
        n_checks++;
        if (ram_ctl !== 30'h0) begin n_fail++; $display("FAIL reset_ram_ctl: got %h expected 0", ram_ctl); end
        clear_req();
        tick();
        rst = 1'b0;
    endtask

    // All four read continuously for three cycles: alternating pairs, returns 4 cycles later.
    task automatic test_round_robin();
        logic [3:0] eg [7];
        logic [3:0] ev [7];
        eg = '{4'b0011, 4'b1100, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ev = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b1100, 4'b0011};
        for (int c = 0; c < 7; c++) begin
            clear_req();
            if (c < 3) for (int i = 0; i < NR; i++) set_req(i, 1'b0, 5'(16 + i), 8'h00);
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg[c]) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, bus.gnt, eg[c]); end
            n_checks++;
            if (bus.rvalid !== ev[c]) begin n_fail++; $display("FAIL rr_rvalid c%0d: got %b expected %b", c, bus.rvalid, ev[c]); end
            for (int i = 0; i < NR; i++) begin
                if (ev[c][i]) begin
                    n_checks++;
                    if (rd(i) !== 8'(8'h90 + i)) begin
                        n_fail++; $display("FAIL rr_rdata%0d c%0d: got %h expected %h", i, c, rd(i), 8'(8'h90 + i));
                    end
                end
            end
            tick();
        end
    endtask

    // req0 writes 0xA5 to addr 3, then req2 reads it back (pointer starts at 2).
    task automatic test_write_then_read();
        logic [3:0] eg [6];
        logic [3:0] ev [6];
        eg = '{4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ev = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        for (int c = 0; c < 6; c++) begin
            clear_req();
            if (c == 0) set_req(0, 1'b1, 5'd3, 8'hA5);
            if (c == 1) set_req(2, 1'b0, 5'd3, 8'h00);
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg[c]) begin n_fail++; $display("FAIL wr_rd_gnt c%0d: got %b expected %b", c, bus.gnt, eg[c]); end
            n_checks++;
            if (bus.rvalid !== ev[c]) begin n_fail++; $display("FAIL wr_rd_rvalid c%0d: got %b expected %b", c, bus.rvalid, ev[c]); end
            if (c == 1) begin
                n_checks++;
                if ({ram_en_a, ram_we_a, ram_addr_a, ram_data_a, ram_we_b} !== {1'b1, 1'b1, 5'd3, 8'hA5, 1'b0}) begin
                    n_fail++; $display("FAIL wr_issue: got en=%b we=%b addr=%0d data=%h web=%b expected 1 1 3 a5 0",
                                       ram_en_a, ram_we_a, ram_addr_a, ram_data_a, ram_we_b);
                end
            end
            if (c == 2) begin
                n_checks++;
                if ({ram_en_a, ram_we_a, ram_addr_a} !== {1'b1, 1'b0, 5'd3}) begin
                    n_fail++; $display("FAIL rd_issue: got en=%b we=%b addr=%0d expected 1 0 3", ram_en_a, ram_we_a, ram_addr_a);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (rd(2) !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_rdata2: got %h expected a5", rd(2)); end
            end
            tick();
        end
    endtask

    // req0 and req1 write addr 7 together: req1 deferred one cycle; req3 then reads 0x22.
    task automatic test_write_conflict();
        logic [3:0] eg [7];
        logic [3:0] ev [7];
        eg = '{4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ev = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
        for (int c = 0; c < 7; c++) begin
            clear_req();
            if (c == 0) set_req(0, 1'b1, 5'd7, 8'h11);
            if (c <= 1) set_req(1, 1'b1, 5'd7, 8'h22);
            if (c == 2) set_req(3, 1'b0, 5'd7, 8'h00);
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg[c]) begin n_fail++; $display("FAIL conflict_gnt c%0d: got %b expected %b", c, bus.gnt, eg[c]); end
            n_checks++;
            if (bus.rvalid !== ev[c]) begin n_fail++; $display("FAIL conflict_rvalid c%0d: got %b expected %b", c, bus.rvalid, ev[c]); end
            if (c == 6) begin
                n_checks++;
                if (rd(3) !== 8'h22) begin n_fail++; $display("FAIL conflict_rdata3: got %h expected 22", rd(3)); end
            end
            tick();
        end
    endtask

    // Same cycle: req1 writes 0x5A to addr 9 (port A), req2 reads addr 9 (port B) -> old 0x00.
    task automatic test_read_during_write();
        logic [3:0] eg [6];
        logic [3:0] ev [6];
        eg = '{4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ev = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
        for (int c = 0; c < 6; c++) begin
            clear_req();
            if (c == 0) set_req(1, 1'b1, 5'd9, 8'h5A);
            if (c <= 1) set_req(2, 1'b0, 5'd9, 8'h00);
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== eg[c]) begin n_fail++; $display("FAIL rdw_gnt c%0d: got %b expected %b", c, bus.gnt, eg[c]); end
            n_checks++;
            if (bus.rvalid !== ev[c]) begin n_fail++; $display("FAIL rdw_rvalid c%0d: got %b expected %b", c, bus.rvalid, ev[c]); end
            if (c == 1) begin
                n_checks++;
                if ({ram_en_a, ram_we_a, ram_addr_a, ram_data_a, ram_en_b, ram_we_b, ram_addr_b} !==
                    {1'b1, 1'b1, 5'd9, 8'h5A, 1'b1, 1'b0, 5'd9}) begin
                    n_fail++; $display("FAIL rdw_issue: got a=%b%b/%0d/%h b=%b%b/%0d expected a=11/9/5a b=10/9",
                                       ram_en_a, ram_we_a, ram_addr_a, ram_data_a, ram_en_b, ram_we_b, ram_addr_b);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (rd(2) !== 8'h00) begin n_fail++; $display("FAIL rdw_old_rdata2: got %h expected 00", rd(2)); end
            end
            if (c == 5) begin
                n_checks++;
                if (rd(2) !== 8'h5A) begin n_fail++; $display("FAIL rdw_new_rdata2: got %h expected 5a", rd(2)); end
            end
            tick();
        end
    endtask

    // req3 reads addr 20..23 on four consecutive cycles: four in-order returns.
    task automatic test_back_to_back();
        logic [3:0] ev [9];
        ev = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
        for (int c = 0; c < 9; c++) begin
            clear_req();
            if (c < 4) set_req(3, 1'b0, 5'(20 + c), 8'h00);
            @(negedge clk);
            n_checks++;
            if (bus.gnt !== ((c < 4) ? 4'b1000 : 4'b0000)) begin
                n_fail++; $display("FAIL b2b_gnt c%0d: got %b expected %b", c, bus.gnt, (c < 4) ? 4'b1000 : 4'b0000);
            end
            n_checks++;
            if (bus.rvalid !== ev[c]) begin n_fail++; $display("FAIL b2b_rvalid c%0d: got %b expected %b", c, bus.rvalid, ev[c]); end
            if (ev[c][3]) begin
                n_checks++;
                if (rd(3) !== 8'(8'h94 + c - 4)) begin
                    n_fail++; $display("FAIL b2b_rdata3 c%0d: got %h expected %h", c, rd(3), 8'(8'h94 + c - 4));
                end
            end
            if (c >= 1) begin
                n_checks++;
                if (ram_en_a !== (c <= 6)) begin
                    n_fail++; $display("FAIL b2b_en_a c%0d: got %b expected %b", c, ram_en_a, (c <= 6));
                end
            end
            tick();
        end
    endtask

    // Reset asserted mid-burst: outputs clear at once, pending reads never return, ptr back to 0.
    task automatic test_reset_mid_burst();
        clear_req();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 5'(16 + i), 8'h00);
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 4'b0011) begin n_fail++; $display("FAIL midrst_gnt0: got %b expected 0011", bus.gnt); end
        tick();
        #1;
        n_checks++;
        if (bus.gnt !== 4'b1100) begin n_fail++; $display("FAIL midrst_gnt1: got %b expected 1100", bus.gnt); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt_clr: got %b expected 0000", bus.gnt); end
        n_checks++;
        if (bus.rvalid !== 4'b0000) begin n_fail++; $display("FAIL midrst_rvalid_clr: got %b expected 0000", bus.rvalid); end
        n_checks++;
        if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata_clr: got %h expected 0", bus.rdata); end
        n_checks++;
        if (ram_ctl !== 30'h0) begin n_fail++; $display("FAIL midrst_ram_ctl_clr: got %h expected 0", ram_ctl); end
        clear_req();
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rvalid !== 4'b0000) begin n_fail++; $display("FAIL midrst_no_return c%0d: got %b expected 0000", c, bus.rvalid); end
            tick();
        end
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 5'(16 + i), 8'h00);
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 4'b0011) begin n_fail++; $display("FAIL midrst_ptr: got %b expected 0011", bus.gnt); end
        tick();
        clear_req();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_req();
        test_reset();
        test_round_robin();
        test_write_then_read();
        test_write_conflict();
        test_read_during_write();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
